// File: rtl/scytale_encryption.sv
// Scytale transposition encryptor: buffers a row-major plaintext frame, then on
// the start token emits it column by column using the sampled key_N x key_M grid.
module scytale_encryption #(
  parameter int                  D_WIDTH                = 8,
  parameter int                  KEY_WIDTH              = 8,
  parameter int                  MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]  START_ENCRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);
  localparam int PROD_W = 2 * KEY_WIDTH;

  typedef enum logic {LOAD, EMIT} state_t;

  state_t               state_q, state_d;
  logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];
  logic [CNT_W-1:0]     count_q;
  logic [KEY_WIDTH-1:0] n_q, m_q;
  logic [KEY_WIDTH-1:0] row_q, col_q;
  logic                 last_q;

  logic [PROD_W-1:0]    key_prod;
  logic [PROD_W-1:0]    rd_idx;
  logic [D_WIDTH-1:0]   rd_data;
  logic                 keys_ok;
  logic                 token_hit;
  logic                 buf_full;
  logic                 row_last;
  logic                 col_last;

  // Product is formed at double key width so large keys cannot wrap into range.
  assign key_prod  = PROD_W'(key_N) * PROD_W'(key_M);
  assign keys_ok   = (key_N != '0) && (key_M != '0) &&
                     (key_prod <= PROD_W'(MAX_NOF_CHARS));
  assign token_hit = (data_i == START_ENCRYPTION_TOKEN);
  assign buf_full  = (count_q == CNT_W'(MAX_NOF_CHARS));
  assign row_last  = (row_q == n_q - KEY_WIDTH'(1));
  assign col_last  = (col_q == m_q - KEY_WIDTH'(1));
  // Plaintext is stored row-major, so grid cell (r, c) lives at r*M + c.
  assign rd_idx    = PROD_W'(row_q) * PROD_W'(m_q) + PROD_W'(col_q);

  // Read mux over the buffer; compare at full index width to avoid truncation.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < MAX_NOF_CHARS; i++) begin
      if (rd_idx == PROD_W'(i)) rd_data = buf_q[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic: leave LOAD only on an acceptable token, leave EMIT after the drain cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (valid_i && token_hit && keys_ok) state_d = EMIT;
      EMIT:    if (last_q) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Buffer fill, key capture, column-major readout and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_NOF_CHARS; i++) buf_q[i] <= '0;
      count_q <= '0;
      n_q     <= '0;
      m_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          valid_o <= 1'b0;
          if (valid_i) begin
            if (token_hit) begin
              if (keys_ok) begin
                n_q    <= key_N;
                m_q    <= key_M;
                row_q  <= '0;
                col_q  <= '0;
                last_q <= 1'b0;
                busy   <= 1'b1;
              end else begin
                // Rejected keys abandon the whole frame.
                for (int i = 0; i < MAX_NOF_CHARS; i++) buf_q[i] <= '0;
                count_q <= '0;
              end
            end else if (!buf_full) begin
              for (int i = 0; i < MAX_NOF_CHARS; i++) begin
                if (count_q == CNT_W'(i)) buf_q[i] <= data_i;
              end
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (last_q) begin
            // Drain cycle after the final character: drop flags, wipe the frame.
            valid_o <= 1'b0;
            busy    <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < MAX_NOF_CHARS; i++) buf_q[i] <= '0;
          end else begin
            data_o  <= rd_data;
            valid_o <= 1'b1;
            // Rows run fastest, columns outer.
            if (row_last) begin
              row_q <= '0;
              if (col_last) begin
                col_q  <= '0;
                last_q <= 1'b1;
              end else begin
                col_q <= col_q + KEY_WIDTH'(1);
              end
            end else begin
              row_q <= row_q + KEY_WIDTH'(1);
            end
          end
        end
        default: valid_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_scytale_encryption.sv
// Self-checking bench for scytale_encryption using an expected-output queue.
module tb_scytale_encryption;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N;
  logic [7:0] key_M;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] pt_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit gap, timed_out, saw_busy, first_valid;

  scytale_encryption dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  // Reference scytale model: column-major walk over a row-major grid, 50-char buffer.
  task automatic model(input int n, input int m);
    int idx;
    exp_q.delete();
    for (int c = 0; c < m; c++)
      for (int r = 0; r < n; r++) begin
        idx = r * m + c;
        exp_q.push_back((idx < pt_q.size() && idx < 50) ? pt_q[idx] : 8'h00);
      end
  endtask

  // Drive plaintext from pt_q followed by the token, one char per cycle.
  task automatic send_frame(input logic [7:0] n, input logic [7:0] m);
    key_N = n;
    key_M = m;
    foreach (pt_q[i]) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = pt_q[i];
    end
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = 8'hFA;
  endtask

  // Record the output stream until busy falls (or budget expires); optionally disturb inputs.
  task automatic collect(input int budget, input bit inject);
    bit started, ended;
    int cyc;
    got_q.delete();
    gap = 0; timed_out = 0; saw_busy = 0; started = 0; ended = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (cyc == 0) first_valid = valid_o;
      if (busy) saw_busy = 1;
      if (valid_o) begin
        if (ended) gap = 1;
        started = 1;
        got_q.push_back(data_o);
      end else if (started) ended = 1;
      if (inject) begin
        valid_i = 1'b1;
        data_i  = (cyc % 2 == 1) ? 8'hFA : "Z";
        key_N   = cyc[7:0];
        key_M   = 8'd3;
      end else valid_i = 1'b0;
      cyc++;
      if (saw_busy && !busy) break;
      if (cyc >= budget) begin timed_out = 1; break; end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; key_N = '0; key_M = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (data_o !== 8'h00 || valid_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: data_o=%h valid_o=%b busy=%b, required 00/0/0", data_o, valid_o, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] e, g;
    pt_q  = '{"A", "B", "C", "D", "E", "F"};
    exp_q = '{"A", "D", "B", "E", "C", "F"};
    send_frame(8'd2, 8'd3);
    collect(40, 0);
    checks++;
    if (!saw_busy || first_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_first: saw_busy=%b first_valid=%b, required 1/0", saw_busy, first_valid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL basic_data: got %h expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0 || gap || timed_out) begin
      errors++;
      $display("FAIL basic_stream: extra=%0d gap=%b timeout=%b, required 0/0/0", got_q.size(), gap, timed_out);
    end
    checks++;
    if (busy !== 1'b0 || valid_o !== 1'b0 || data_o !== "F") begin
      errors++;
      $display("FAIL basic_end: busy=%b valid_o=%b data_o=%h, required 0/0/46", busy, valid_o, data_o);
    end
  endtask

  task automatic test_padding();
    logic [7:0] e, g;
    pt_q  = '{"A", "B", "C", "D"};
    exp_q = '{"A", "C", 8'h00, "B", "D", 8'h00};
    send_frame(8'd3, 8'd2);
    collect(40, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL padding_data: got %h expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0 || gap || timed_out) begin
      errors++;
      $display("FAIL padding_stream: extra=%0d gap=%b timeout=%b, required 0/0/0", got_q.size(), gap, timed_out);
    end
    // Empty frame with valid keys still emits, all zeros.
    pt_q.delete();
    model(2, 2);
    send_frame(8'd2, 8'd2);
    collect(40, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL empty_data: got %h expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0 || timed_out) begin
      errors++;
      $display("FAIL empty_stream: extra=%0d timeout=%b, required 0/0", got_q.size(), timed_out);
    end
  endtask

  task automatic test_discard();
    logic [7:0] e, g;
    pt_q = '{"P", "Q", "R", "S"};
    exp_q = '{"P", "Q"};
    send_frame(8'd1, 8'd2);
    collect(40, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL discard_first: got %h expected %h", g, e); end
    end
    // Leftover R,S must not leak into the next frame.
    pt_q  = '{"a", "b"};
    exp_q = '{"a", 8'h00, "b", 8'h00};
    send_frame(8'd2, 8'd2);
    collect(40, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL discard_next: got %h expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0 || timed_out) begin
      errors++;
      $display("FAIL discard_stream: extra=%0d timeout=%b, required 0/0", got_q.size(), timed_out);
    end
  endtask

  task automatic test_invalid_keys();
    logic [7:0] e, g;
    pt_q = '{"A", "B", "C"};
    send_frame(8'd0, 8'd3);
    collect(6, 0);
    checks++;
    if (saw_busy || got_q.size() != 0) begin
      errors++;
      $display("FAIL invalid_zero: busy_seen=%b outputs=%0d, required 0/0", saw_busy, got_q.size());
    end
    pt_q.delete();
    send_frame(8'd6, 8'd10);
    collect(6, 0);
    checks++;
    if (saw_busy || got_q.size() != 0) begin
      errors++;
      $display("FAIL invalid_big: busy_seen=%b outputs=%0d, required 0/0", saw_busy, got_q.size());
    end
    pt_q  = '{"X", "Y"};
    exp_q = '{"X", "Y"};
    send_frame(8'd1, 8'd2);
    collect(40, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL invalid_recover: got %h expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0 || timed_out) begin
      errors++;
      $display("FAIL invalid_stream: extra=%0d timeout=%b, required 0/0", got_q.size(), timed_out);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] e, g;
    int n_exp;
    pt_q.delete();
    for (int i = 0; i < 55; i++) pt_q.push_back(8'h10 + 8'(i));
    model(5, 10);
    n_exp = exp_q.size();
    send_frame(8'd5, 8'd10);
    collect(200, 0);
    checks++;
    if (got_q.size() != n_exp || gap || timed_out) begin
      errors++;
      $display("FAIL overflow_count: got %0d outputs gap=%b timeout=%b, required %0d/0/0",
               got_q.size(), gap, timed_out, n_exp);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL overflow_data: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_back_to_back_inputs();
    logic [7:0] e, g;
    pt_q  = '{"G", "H", "I", "J"};
    exp_q = '{"G", "I", "H", "J"};
    send_frame(8'd2, 8'd2);
    collect(40, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL ignore_data: got %h expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0 || gap || timed_out) begin
      errors++;
      $display("FAIL ignore_stream: extra=%0d gap=%b timeout=%b, required 0/0/0", got_q.size(), gap, timed_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_restart: busy=%b valid_o=%b, required 0/0", busy, valid_o);
    end
  endtask

  task automatic test_reset_mid_emit();
    logic [7:0] e, g;
    int seen;
    bit hit;
    pt_q = '{"A", "B", "C", "D", "E", "F"};
    send_frame(8'd2, 8'd3);
    seen = 0; hit = 0;
    for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
      @(negedge clk);
      valid_i = 1'b0;
      if (valid_o) begin
        seen++;
        if (seen == 3) begin
          hit = 1;
          checks++;
          if (data_o !== "B") begin errors++; $display("FAIL midrst_third: got %h expected 42", data_o); end
          rst_n = 1'b0;
          #1;
          checks++;
          if (data_o !== 8'h00 || valid_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: data_o=%h valid_o=%b busy=%b, required 00/0/0", data_o, valid_o, busy);
          end
        end
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midrst_timeout: saw %0d outputs, required 3", seen); end
    @(negedge clk);
    rst_n = 1'b1;
    pt_q  = '{"K", "L"};
    exp_q = '{"K", 8'h00, "L", 8'h00};
    send_frame(8'd2, 8'd2);
    collect(40, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL midrst_after: got %h expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0 || timed_out) begin
      errors++;
      $display("FAIL midrst_stream: extra=%0d timeout=%b, required 0/0", got_q.size(), timed_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_discard();
    test_invalid_keys();
    test_overflow();
    test_back_to_back_inputs();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
